// File: rtl/switch_irq_pkg.sv
// Shared definitions for the DIP-switch interrupt controller.
//   DEFAULT_BASE_ADDR : byte address of DATA word 0 on the MIPS bridge
//   CNT_W             : width of each per-byte debounce counter
//   off_ie / off_is   : byte offsets of the IE and IS registers, which sit
//                       directly after the N_WORDS data words
package switch_irq_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_7f2c;
  localparam int          CNT_W             = 16;

  function automatic logic [31:0] off_ie(input int n_words);
    return 32'(4 * n_words);
  endfunction

  function automatic logic [31:0] off_is(input int n_words);
    return 32'(4 * n_words + 4);
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// One 8-bit switch group: polarity fix, two-flop synchroniser, debounce
// counter and the accepted (stable) value.
//   clk, reset  : system clock, asynchronous active-high reset
//   i_raw       : raw switch pins for this group
//   o_stable    : debounced value
//   o_changed   : high in the cycle whose rising edge loads a new stable value
module switch_debounce
  import switch_irq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_raw,
  output logic [7:0] o_stable,
  output logic       o_changed
);

  localparam logic [7:0]       INV_MASK = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       r_sync_p0;
  logic [7:0]       r_sync_p1;
  logic [7:0]       r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;
  logic             w_accept;

  // The count only tracks "how long has sync differed from stable"; the
  // mismatching value itself may wander without restarting it.
  assign w_diff   = (r_sync_p1 != r_stable);
  assign w_accept = w_diff && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
      r_stable  <= '0;
      r_cnt     <= '0;
    end else begin
      // stage p0: capture pins, stage p1: metastability settle
      r_sync_p0 <= i_raw ^ INV_MASK;
      r_sync_p1 <= r_sync_p0;
      // debounce stage
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_stable <= r_sync_p1;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable  = r_stable;
  assign o_changed = w_accept;

endmodule

// File: rtl/switch_irq_ctrl.sv
// Memory-mapped DIP-switch controller with per-group change interrupts.
//   clk, reset : system clock, asynchronous active-high reset
//   Addr/WE/Din: bridge write port (byte address, Addr[1:0] ignored)
//   Dout       : combinational read data for Addr (0 outside the window)
//   IRQ        : OR of pending-and-enabled group interrupts
//   dip_switch : raw pins, byte k on bits [8k+7:8k]
// Map: DATA[0..N_WORDS-1] (RO), IE (RW), IS (write-1-to-clear).
module switch_irq_ctrl
  import switch_irq_pkg::*;
#(
  parameter int          N_BYTES         = 8,
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter logic [31:0] BASE_ADDR       = DEFAULT_BASE_ADDR
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            Addr,
  input  logic                   WE,
  input  logic [31:0]            Din,
  output logic [31:0]            Dout,
  output logic                   IRQ,
  input  logic [8*N_BYTES-1:0]   dip_switch
);

  localparam int          N_WORDS  = N_BYTES / 4;
  localparam logic [31:0] OFF_IE_L = off_ie(N_WORDS);
  localparam logic [31:0] OFF_IS_L = off_is(N_WORDS);
  localparam logic [31:0] SPAN     = OFF_IS_L + 32'd4;

  logic [8*N_BYTES-1:0] w_stable;
  logic [N_BYTES-1:0]   w_changed;
  logic [N_BYTES-1:0]   r_ie;
  logic [N_BYTES-1:0]   r_is;
  logic [31:0]          w_off;
  logic [31:0]          w_word_off;
  logic                 w_hit;
  logic                 w_wr_ie;
  logic                 w_wr_is;
  logic [N_BYTES-1:0]   w_clr;

  for (genvar k = 0; k < N_BYTES; k++) begin : g_byte
    switch_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_debounce (
      .clk       (clk),
      .reset     (reset),
      .i_raw     (dip_switch[8*k +: 8]),
      .o_stable  (w_stable[8*k +: 8]),
      .o_changed (w_changed[k])
    );
  end

  // Subtracting first keeps the window test a single unsigned compare and
  // makes the decode independent of where BASE_ADDR sits.
  assign w_off      = Addr - BASE_ADDR;
  assign w_hit      = (Addr >= BASE_ADDR) && (w_off < SPAN);
  assign w_word_off = {w_off[31:2], 2'b00};
  assign w_wr_ie    = WE && w_hit && (w_word_off == OFF_IE_L);
  assign w_wr_is    = WE && w_hit && (w_word_off == OFF_IS_L);
  assign w_clr      = w_wr_is ? Din[N_BYTES-1:0] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ie <= '0;
      r_is <= '0;
    end else begin
      if (w_wr_ie) begin
        r_ie <= Din[N_BYTES-1:0];
      end
      // OR-ing the new events after the clear lets a same-edge set win.
      r_is <= (r_is & ~w_clr) | w_changed;
    end
  end

  always_comb begin
    Dout = '0;
    if (w_hit) begin
      if (w_word_off == OFF_IE_L) begin
        Dout[N_BYTES-1:0] = r_ie;
      end else if (w_word_off == OFF_IS_L) begin
        Dout[N_BYTES-1:0] = r_is;
      end else begin
        for (int w = 0; w < N_WORDS; w++) begin
          if (w_word_off == 32'(4 * w)) begin
            Dout = w_stable[32*w +: 32];
          end
        end
      end
    end
  end

  assign IRQ = |(r_ie & r_is);

endmodule

// File: tb/tb_switch_irq_ctrl.sv
module tb_switch_irq_ctrl;

  localparam int          NB   = 8;
  localparam int          NW   = NB / 4;
  localparam int          DC   = 4;
  localparam logic [31:0] BASE = 32'h0000_7f2c;
  localparam logic [31:0] A_D0 = BASE;
  localparam logic [31:0] A_D1 = BASE + 32'd4;
  localparam logic [31:0] A_IE = BASE + 32'd8;
  localparam logic [31:0] A_IS = BASE + 32'd12;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   Addr = BASE;
  logic          WE = 1'b0;
  logic [31:0]   Din = '0;
  logic [31:0]   Dout;
  logic          IRQ;
  logic [63:0]   dip = '0;

  logic [31:0]   Addr16 = BASE;
  logic          we16 = 1'b0;
  logic [31:0]   din16 = '0;
  logic [31:0]   Dout16;
  logic          IRQ16;
  logic [127:0]  dip16 = '1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  switch_irq_ctrl #(.N_BYTES(NB), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1'b1), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din),
    .Dout(Dout), .IRQ(IRQ), .dip_switch(dip)
  );

  switch_irq_ctrl #(.N_BYTES(16), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1'b1), .BASE_ADDR(BASE)) dut16 (
    .clk(clk), .reset(reset), .Addr(Addr16), .WE(we16), .Din(din16),
    .Dout(Dout16), .IRQ(IRQ16), .dip_switch(dip16)
  );

  // Reference model: a group accepts the current synchronised value when the
  // last DC synchronised samples all differ from its accepted value. The
  // synchronised sample seen at an edge is the inverted pin word captured two
  // edges earlier (0 until two edges have passed since reset).
  logic [63:0]   m_raw_q[$];
  logic [63:0]   m_s2_q[$];
  logic [63:0]   m_stab;
  logic [NB-1:0] m_ie;
  logic [NB-1:0] m_is;

  always @(posedge clk or posedge reset) begin : model
    logic [63:0]   cur;
    logic [NB-1:0] set, clr;
    logic [31:0]   off;
    bit            all;
    if (reset) begin
      m_raw_q.delete();
      m_s2_q.delete();
      m_stab = '0;
      m_ie   = '0;
      m_is   = '0;
    end else begin
      cur = (m_raw_q.size() >= 2) ? m_raw_q[m_raw_q.size()-2] : 64'h0;
      m_s2_q.push_back(cur);
      while (m_s2_q.size() > DC) void'(m_s2_q.pop_front());
      set = '0;
      if (m_s2_q.size() == DC) begin
        for (int k = 0; k < NB; k++) begin
          all = 1'b1;
          for (int j = 0; j < DC; j++)
            if (m_s2_q[j][8*k +: 8] == m_stab[8*k +: 8]) all = 1'b0;
          if (all) begin
            m_stab[8*k +: 8] = cur[8*k +: 8];
            set[k] = 1'b1;
          end
        end
      end
      m_raw_q.push_back(~dip);
      while (m_raw_q.size() > 2) void'(m_raw_q.pop_front());
      clr = '0;
      off = Addr - BASE;
      if (WE && Addr >= BASE && off < 32'(4*(NW+2))) begin
        if (off[31:2] == 30'(NW))     m_ie = Din[NB-1:0];
        if (off[31:2] == 30'(NW + 1)) clr  = Din[NB-1:0];
      end
      m_is = (m_is & ~clr) | set;
    end
  end

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (a < BASE || off >= 32'(4*(NW+2))) return 32'h0;
    if (off[31:2] < 30'(NW)) return m_stab[32*off[31:2] +: 32];
    if (off[31:2] == 30'(NW)) return 32'(m_ie);
    return 32'(m_is);
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    Addr = a;
    Din  = d;
    WE   = 1'b1;
    step();
    WE   = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    Addr = a;
    #1;
    d = Dout;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    dip   = '0;
    dip16 = '1;
    step(2);
    #1 reset = 1'b1;
    #1;
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b expected 0", IRQ); end
    bus_read(A_D0, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_data0: got %h expected 00000000", rd); end
    bus_read(A_IE, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_ie: got %h expected 00000000", rd); end
    bus_read(A_IS, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_is: got %h expected 00000000", rd); end
    step(2);
    reset = 1'b0;
    step(5);
    bus_read(A_D0, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_data_edge5: got %h expected 00000000", rd); end
    bus_read(A_IS, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_is_edge5: got %h expected 00000000", rd); end
    step(1);
    bus_read(A_D0, rd);
    total++; if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_data0_edge6: got %h expected ffffffff", rd); end
    bus_read(A_D1, rd);
    total++; if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_data1_edge6: got %h expected ffffffff", rd); end
    bus_read(A_IS, rd);
    total++; if (rd !== 32'h0000_00FF) begin bad++; $display("FAIL reset_is_edge6: got %h expected 000000ff", rd); end
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL reset_irq_masked: got %b expected 0", IRQ); end
    bus_write(A_IS, 32'hFF);
  endtask

  task automatic test_latency();
    logic [31:0] rd;
    dip[7:0] = 8'hFF;
    step(8);
    bus_write(A_IS, 32'hFF);
    bus_write(A_IE, 32'h01);
    dip[7:0] = 8'hFE;
    step(5);
    bus_read(A_D0, rd);
    total++; if (rd[7:0] !== 8'h00) begin bad++; $display("FAIL lat_data_edge5: got %h expected 00", rd[7:0]); end
    bus_read(A_IS, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL lat_is_edge5: got %h expected 00000000", rd); end
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL lat_irq_edge5: got %b expected 0", IRQ); end
    step(1);
    bus_read(A_D0, rd);
    total++; if (rd[7:0] !== 8'h01) begin bad++; $display("FAIL lat_data_edge6: got %h expected 01", rd[7:0]); end
    bus_read(A_IS, rd);
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL lat_is_edge6: got %h expected 00000001", rd); end
    total++; if (IRQ !== 1'b1) begin bad++; $display("FAIL lat_irq_edge6: got %b expected 1", IRQ); end
    bus_write(A_IS, 32'h01);
    bus_write(A_IE, 32'h00);
  endtask

  task automatic test_glitch();
    logic [31:0] rd;
    bus_write(A_IE, 32'h08);
    dip[31:24] = 8'h55;
    step(3);
    dip[31:24] = 8'h00;
    step(10);
    bus_read(A_D0, rd);
    total++; if (rd !== 32'hFFFF_FF01) begin bad++; $display("FAIL glitch_data: got %h expected ffffff01", rd); end
    bus_read(A_IS, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL glitch_is: got %h expected 00000000", rd); end
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL glitch_irq: got %b expected 0", IRQ); end
    bus_write(A_IE, 32'h00);
  endtask

  task automatic test_mask_w1c();
    logic [31:0] rd;
    dip[47:40] = 8'h0F;
    step(8);
    bus_read(A_IS, rd);
    total++; if (rd !== 32'h20) begin bad++; $display("FAIL mask_is_set: got %h expected 00000020", rd); end
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL mask_irq_off: got %b expected 0", IRQ); end
    bus_write(A_IS, 32'h00);
    bus_read(A_IS, rd);
    total++; if (rd !== 32'h20) begin bad++; $display("FAIL w1c_zero: got %h expected 00000020", rd); end
    bus_write(A_IE, 32'h20);
    total++; if (IRQ !== 1'b1) begin bad++; $display("FAIL mask_irq_on: got %b expected 1", IRQ); end
    bus_read(A_IE, rd);
    total++; if (rd !== 32'h20) begin bad++; $display("FAIL ie_readback: got %h expected 00000020", rd); end
    bus_write(A_IS, 32'h20);
    bus_read(A_IS, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL w1c_clear: got %h expected 00000000", rd); end
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL w1c_irq: got %b expected 0", IRQ); end
    bus_write(A_IE, 32'h00);
  endtask

  task automatic test_simultaneous();
    logic [31:0] rd;
    dip[23:16] = 8'h33;
    step(5);
    bus_write(A_IS, 32'h04);
    bus_read(A_IS, rd);
    total++; if (rd !== 32'h04) begin bad++; $display("FAIL simul_set_wins: got %h expected 00000004", rd); end
    bus_read(A_D0, rd);
    total++; if (rd !== 32'hFFCC_FF01) begin bad++; $display("FAIL simul_data: got %h expected ffccff01", rd); end
    bus_write(A_IS, 32'h04);
    bus_read(A_IS, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL simul_clear: got %h expected 00000000", rd); end
  endtask

  task automatic test_decode();
    logic [31:0] rd;
    bus_read(BASE + 32'd16, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL dec_miss_high: got %h expected 00000000", rd); end
    bus_read(BASE - 32'd4, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL dec_miss_low: got %h expected 00000000", rd); end
    bus_write(A_D0, 32'h1234_5678);
    bus_read(A_D0 + 32'd3, rd);
    total++; if (rd !== 32'hFFCC_FF01) begin bad++; $display("FAIL dec_data_ro: got %h expected ffccff01", rd); end
    bus_read(A_D1, rd);
    total++; if (rd !== 32'hFFFF_F0FF) begin bad++; $display("FAIL dec_data1: got %h expected fffff0ff", rd); end
    bus_write(BASE + 32'd16, 32'hFF);
    bus_write(A_IE + 32'd3, 32'h05);
    bus_read(A_IE, rd);
    total++; if (rd !== 32'h05) begin bad++; $display("FAIL dec_ie_lowbits: got %h expected 00000005", rd); end
    bus_write(A_IE, 32'h00);
    dip16[103:96] = 8'h00;
    step(8);
    Addr16 = BASE + 32'h14;
    #1;
    total++; if (Dout16 !== 32'h0000_1000) begin bad++; $display("FAIL dec16_is: got %h expected 00001000", Dout16); end
    Addr16 = BASE + 32'h0C;
    #1;
    total++; if (Dout16 !== 32'h0000_00FF) begin bad++; $display("FAIL dec16_data3: got %h expected 000000ff", Dout16); end
    Addr16 = BASE + 32'h10;
    #1;
    total++; if (Dout16 !== 32'h0) begin bad++; $display("FAIL dec16_ie: got %h expected 00000000", Dout16); end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, exp;
    int r;
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < NB; k++)
        if ($urandom_range(0, 11) == 0) dip[8*k +: 8] = 8'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0)      begin Addr = A_IE; Din = $urandom; WE = 1'b1; end
      else if (r == 1) begin Addr = A_IS; Din = $urandom; WE = 1'b1; end
      else if (r == 2) begin Addr = BASE + 32'($urandom_range(0, 7)); Din = $urandom; WE = 1'b1; end
      else if (r == 3) begin Addr = BASE + 32'($urandom_range(16, 40)); Din = $urandom; WE = 1'b1; end
      step();
      WE = 1'b0;
      if (i == 300) begin
        #1 reset = 1'b1;
        #1 reset = 1'b0;
      end
      a = BASE - 32'd8 + 32'($urandom_range(0, 31));
      bus_read(a, rd);
      exp = m_read(a);
      total++; if (rd !== exp) begin bad++; $display("FAIL rand_read @%h cycle %0d: got %h expected %h", a, i, rd, exp); end
      total++; if (IRQ !== |(m_ie & m_is)) begin bad++; $display("FAIL rand_irq cycle %0d: got %b expected %b", i, IRQ, |(m_ie & m_is)); end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_mask_w1c();
    test_simultaneous();
    test_decode();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switch_irq_ctrl.md
# switch_irq_ctrl

Parametrised, memory-mapped DIP-switch input controller for the MIPS CPU bridge. Samples `N_BYTES` 8-bit switch groups through a two-flop synchroniser and per-byte debouncer, exposes the debounced values as read-only words, and raises a maskable, sticky, write-1-to-clear interrupt per byte group on every debounced change. It replaces the fixed 64-bit switch driver and sits on the bridge alongside the other peripherals; `IRQ` feeds one hardware-interrupt line of CP0.

## Interface
- `N_BYTES`, 8, number of 8-bit switch groups; multiple of 4, range 4..16; `N_WORDS = N_BYTES/4`
- `DEBOUNCE_CYCLES`, 4, consecutive mismatching cycles required to accept a change; range 1..65535
- `ACTIVE_LOW`, 1, 1 = invert raw inputs (switch on = pin low)
- `BASE_ADDR`, 32'h0000_7f2c, byte address of data word 0; word-aligned

- `clk`  in  1  system clock; the block uses this one clock only
- `reset`  in  1  asynchronous, active-high reset
- `Addr`  in  32  bus byte address
- `WE`  in  1  bus write enable
- `Din`  in  32  bus write data
- `Dout`  out  32  bus read data, combinational from `Addr`
- `IRQ`  out  1  interrupt request, `|(IS & IE)`
- `dip_switch`  in  8*N_BYTES  raw switch pins; byte k = bits [8k+7:8k]

## Operation
- Register map (offset from `BASE_ADDR`): 0x0..4*(N_WORDS-1) DATA[w], RO, bytes 4w+3..4w of debounced value, byte 4w in [7:0]; 4*N_WORDS IE, RW, bits [N_BYTES-1:0]; 4*N_WORDS+4 IS, RW1C, bits [N_BYTES-1:0]. Upper unused bits read 0.
- Hit: `BASE_ADDR <= Addr < BASE_ADDR + 4*(N_WORDS+2)`; decode on `Addr[..:2]`, `Addr[1:0]` ignored. Miss → `Dout = 0`, writes ignored. Writes to DATA ignored.
- Input path per byte k: raw (XOR all-ones if `ACTIVE_LOW`) → sync1 → sync2.
- Debounce per byte: `stable[k]` 8b, `cnt[k]` 16b. If `sync2 == stable`: cnt ← 0. Else if cnt == DEBOUNCE_CYCLES-1: stable ← sync2, cnt ← 0, set IS[k]. Else cnt ← cnt+1. Any bit mismatch counts; a change in the mismatching value mid-count does not restart the count.
- IS: bit set on debounced change of byte k regardless of IE; cleared by writing 1 to that bit; writing 0 no effect. Same-cycle set and W1C on one bit → set wins.
- IE write replaces all bits; IRQ updates same cycle as IS/IE registers change (combinational OR).
- Reset: sync flops, stable, cnt, IE, IS all 0; `IRQ` = 0; `Dout` reads DATA = 0. Reset mid-count discards the count; no IS set on deassertion unless inputs then differ from 0 for DEBOUNCE_CYCLES.

## Timing
- Raw input sampled into sync1 at edge E1, sync2 at E2; stable and IS[k] update at E(2+DEBOUNCE_CYCLES) if raw held constant. Default: 6 edges. `IRQ` high directly after that edge if IE[k].
- Glitch held for fewer than DEBOUNCE_CYCLES sync2 cycles: no stable update, no IS.
- Bus read: zero-latency, `Dout` valid in the same cycle as `Addr`. Bus write: takes effect at the rising edge with `WE`=1.

## Structure
- Shared package `switch_irq_pkg`: register offset constants (`OFF_IE`, `OFF_IS` as functions of N_WORDS), default BASE_ADDR, counter width.
- Sub-module `switch_debounce` (one 8-bit group: synchroniser, counter, stable reg, `changed` pulse), instantiated N_BYTES times by generate; top holds IE/IS, decode and read mux.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle with switches all low (ACTIVE_LOW=1) → all DATA read 0xFFFFFFFF after 6 edges with IS=0xFF captured; before that DATA=0, IE=0, IS=0, IRQ=0 immediately on reset.
- Debounce latency: IE=0x01, byte 0 raw 0xFF→0xFE held → DATA[0][7:0]=0x01, IS=0x01, IRQ=1 exactly at edge 6, not 5.
- Glitch reject: byte 3 raw toggled for 3 cycles (DEBOUNCE_CYCLES=4) → DATA unchanged, IS=0, IRQ=0.
- Mask/W1C: change byte 5 with IE=0 → IS=0x20, IRQ=0; write IE=0x20 → IRQ=1; write IS=0x20 → IS=0, IRQ=0; write IS=0x00 earlier → no effect.
- Simultaneous: W1C of IS[2] on the same edge byte 2 debounce completes → IS[2]=1.
- Decode: read BASE_ADDR+4*(N_WORDS+2) → 0; write DATA[0] with 0x12345678 → DATA[0] unchanged; N_BYTES=16 build reads IS at offset 0x14.
